// File: rtl/program_loader.sv
// Boot-time loader: packs a byte stream into RAM words starting at BASE_ADDR,
// then enables the control unit and hands it the RAM bus.
module program_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_len_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [ADDR_W-1:0] cu_addr_i,
  input  logic              cu_read_i,
  input  logic              cu_write_i,
  input  logic [DATA_W-1:0] cu_wdata_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_read_o,
  output logic              ram_write_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              cpu_enable_o,
  output logic              busy_o
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BCNT_W = $clog2(BYTES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wordCnt_q, wordCnt_d;
  logic [BCNT_W-1:0]   byteCnt_q, byteCnt_d;
  logic [DATA_W-1:0]   word_q, word_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      wordCnt_q <= '0;
      byteCnt_q <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      word_q    <= word_d;
    end
  end

  // Load-phase bus values come straight from registers; only RUN muxes in the CU bus.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    addr_d       = addr_q;
    wordCnt_d    = wordCnt_q;
    byteCnt_d    = byteCnt_q;
    word_d       = word_q;
    rx_ready_o   = 1'b0;
    busy_o       = 1'b0;
    cpu_enable_o = 1'b0;
    ram_addr_o   = '0;
    ram_read_o   = 1'b0;
    ram_write_o  = 1'b0;
    ram_wdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          len_d     = load_len_i;
          addr_d    = ADDR_W'(BASE_ADDR);
          wordCnt_d = '0;
          byteCnt_d = '0;
          state_d   = (load_len_i == '0) ? RUN : COLLECT;
        end
      end
      COLLECT: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (rx_valid_i) begin
          word_d[8*int'(byteCnt_q) +: 8] = rx_data_i;
          byteCnt_d = byteCnt_q + 1'b1;
          if (byteCnt_q == BCNT_W'(BYTES - 1)) state_d = WRITE;
        end
      end
      WRITE: begin
        busy_o      = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = addr_q;
        ram_wdata_o = word_q;
        addr_d      = addr_q + 1'b1;
        wordCnt_d   = wordCnt_q + 1'b1;
        byteCnt_d   = '0;
        state_d     = (wordCnt_q == len_q - 1'b1) ? RUN : COLLECT;
      end
      RUN: begin
        cpu_enable_o = 1'b1;
        ram_addr_o   = cu_addr_i;
        ram_read_o   = cu_read_i;
        ram_write_o  = cu_write_i;
        ram_wdata_o  = cu_wdata_i;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (base 1 and base 0xFF)
// share one stimulus stream and are compared every cycle against a transaction model.
module tb_program_loader;

  localparam int BYTES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        loadStart = 1'b0;
  logic [7:0]  loadLen = '0;
  logic [7:0]  rxData = '0;
  logic        rxValid = 1'b0;
  logic [7:0]  cuAddr = '0;
  logic        cuRead = 1'b0;
  logic        cuWrite = 1'b0;
  logic [15:0] cuWdata = '0;

  logic        rxReadyA, ramReadA, ramWriteA, cpuEnA, busyA;
  logic [7:0]  ramAddrA;
  logic [15:0] ramWdataA;
  logic        rxReadyB, ramReadB, ramWriteB, cpuEnB, busyB;
  logic [7:0]  ramAddrB;
  logic [15:0] ramWdataB;

  int compared = 0;
  int failed = 0;

  int          mMode = 0;
  int          mLen = 0;
  int          mWords = 0;
  bit          mPend = 1'b0;
  logic [7:0]  mq[$];

  logic [7:0]  waAddr[$], wbAddr[$];
  logic [15:0] waData[$], wbData[$];

  logic        eRun, eLoad, eWrite, eRead;
  logic [7:0]  eAddrA, eAddrB;
  logic [15:0] eWord, eWdata;

  always #5 clk = ~clk;

  program_loader #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(1)) dut (
    .clk_i(clk), .reset_i(reset), .load_start_i(loadStart), .load_len_i(loadLen),
    .rx_data_i(rxData), .rx_valid_i(rxValid), .rx_ready_o(rxReadyA),
    .cu_addr_i(cuAddr), .cu_read_i(cuRead), .cu_write_i(cuWrite), .cu_wdata_i(cuWdata),
    .ram_addr_o(ramAddrA), .ram_read_o(ramReadA), .ram_write_o(ramWriteA),
    .ram_wdata_o(ramWdataA), .cpu_enable_o(cpuEnA), .busy_o(busyA)
  );

  program_loader #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(255)) dutWrap (
    .clk_i(clk), .reset_i(reset), .load_start_i(loadStart), .load_len_i(loadLen),
    .rx_data_i(rxData), .rx_valid_i(rxValid), .rx_ready_o(rxReadyB),
    .cu_addr_i(cuAddr), .cu_read_i(cuRead), .cu_write_i(cuWrite), .cu_wdata_i(cuWdata),
    .ram_addr_o(ramAddrB), .ram_read_o(ramReadB), .ram_write_o(ramWriteB),
    .ram_wdata_o(ramWdataB), .cpu_enable_o(cpuEnB), .busy_o(busyB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: idle / loading / run, with the bytes of the word being gathered.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mMode = 0; mWords = 0; mPend = 1'b0; mq.delete();
    end else begin
      case (mMode)
        0: if (loadStart) begin
             mLen = int'(loadLen); mWords = 0; mPend = 1'b0; mq.delete();
             mMode = (loadLen == 8'd0) ? 2 : 1;
           end
        1: if (mPend) begin
             mWords++; mPend = 1'b0; mq.delete();
             if (mWords == mLen) mMode = 2;
           end else if (rxValid) begin
             mq.push_back(rxData);
             if (mq.size() == BYTES) mPend = 1'b1;
           end
        default: ;
      endcase
    end
  end

  // Compare both instances against the model halfway through every cycle.
  always @(negedge clk) begin
    if (ramWriteA && !cpuEnA) begin waAddr.push_back(ramAddrA); waData.push_back(ramWdataA); end
    if (ramWriteB && !cpuEnB) begin wbAddr.push_back(ramAddrB); wbData.push_back(ramWdataB); end
    eRun  = (mMode == 2);
    eLoad = (mMode == 1);
    eWord = '0;
    foreach (mq[i]) eWord[8*i +: 8] = mq[i];
    eAddrA = eRun ? cuAddr : (mPend ? 8'(1 + mWords) : 8'h00);
    eAddrB = eRun ? cuAddr : (mPend ? 8'(255 + mWords) : 8'h00);
    eWrite = eRun ? cuWrite : (eLoad && mPend);
    eRead  = eRun ? cuRead : 1'b0;
    eWdata = eRun ? cuWdata : (mPend ? eWord : 16'h0000);
    checkOutput("rx_ready A", 32'(rxReadyA), 32'(eLoad && !mPend));
    checkOutput("busy A", 32'(busyA), 32'(eLoad));
    checkOutput("cpu_enable A", 32'(cpuEnA), 32'(eRun));
    checkOutput("ram_write A", 32'(ramWriteA), 32'(eWrite));
    checkOutput("ram_read A", 32'(ramReadA), 32'(eRead));
    checkOutput("ram_addr A", 32'(ramAddrA), 32'(eAddrA));
    checkOutput("ram_wdata A", 32'(ramWdataA), 32'(eWdata));
    checkOutput("rx_ready B", 32'(rxReadyB), 32'(eLoad && !mPend));
    checkOutput("cpu_enable B", 32'(cpuEnB), 32'(eRun));
    checkOutput("ram_write B", 32'(ramWriteB), 32'(eWrite));
    checkOutput("ram_addr B", 32'(ramAddrB), 32'(eAddrB));
    checkOutput("ram_wdata B", 32'(ramWdataB), 32'(eWdata));
  end

  task automatic applyStimulus(input logic ld, input logic [7:0] len);
    loadStart = ld; loadLen = len;
    @(negedge clk); #1;
    loadStart = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    waAddr.delete(); waData.delete(); wbAddr.delete(); wbData.delete();
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    logic acc;
    bit done;
    done = 1'b0;
    repeat (gap) begin @(negedge clk); #1; end
    rxValid = 1'b1; rxData = b;
    for (int i = 0; i < 40 && !done; i++) begin
      acc = rxReadyA;
      @(negedge clk); #1;
      if (acc) done = 1'b1;
    end
    rxValid = 1'b0;
    if (!done) begin
      compared++; failed++;
      $display("[TB] FAIL byte accept timeout: got no ready, expected ready for 0x%0h", b);
    end
  endtask

  task automatic waitRun();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (cpuEnA) done = 1'b1;
      else begin @(negedge clk); #1; end
    end
    checkOutput("run reached", 32'(done), 32'd1);
  endtask

  task automatic checkTwoWords();
    checkOutput("writes A", waAddr.size(), 2);
    checkOutput("writes B", wbAddr.size(), 2);
    if (waAddr.size() == 2 && wbAddr.size() == 2) begin
      checkOutput("A addr0", 32'(waAddr[0]), 32'h01);
      checkOutput("A data0", 32'(waData[0]), 32'h1234);
      checkOutput("A addr1", 32'(waAddr[1]), 32'h02);
      checkOutput("A data1", 32'(waData[1]), 32'hABCD);
      checkOutput("B addr0", 32'(wbAddr[0]), 32'hFF);
      checkOutput("B addr1 wrap", 32'(wbAddr[1]), 32'h00);
      checkOutput("B data1", 32'(wbData[1]), 32'hABCD);
    end
  endtask

  initial begin
    $display("[TB] start");
    doReset();
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset cpu_enable", 32'(cpuEnA), 32'd0);

    $display("[TB] back-to-back two-word load");
    applyStimulus(1'b1, 8'd2);
    sendByte(8'h34, 0); sendByte(8'h12, 0);
    sendByte(8'hCD, 0); sendByte(8'hAB, 0);
    waitRun();
    checkOutput("t1 busy after load", 32'(busyA), 32'd0);
    checkTwoWords();

    $display("[TB] gapped load with byte offered during WRITE");
    doReset();
    applyStimulus(1'b1, 8'd2);
    sendByte(8'h34, 3); sendByte(8'h12, 3);
    checkOutput("t2 ready in WRITE", 32'(rxReadyA), 32'd0);
    sendByte(8'hCD, 0); sendByte(8'hAB, 3);
    waitRun();
    repeat (3) begin @(negedge clk); #1; end
    checkTwoWords();

    $display("[TB] zero-length load and CU pass-through");
    doReset();
    applyStimulus(1'b1, 8'd0);
    checkOutput("t3 cpu_enable", 32'(cpuEnA), 32'd1);
    checkOutput("t3 writes", waAddr.size(), 0);
    cuAddr = 8'h05; cuRead = 1'b1; #1;
    checkOutput("t4 run addr", 32'(ramAddrA), 32'h05);
    checkOutput("t4 run read", 32'(ramReadA), 32'd1);
    @(negedge clk); #1;
    cuRead = 1'b0;

    $display("[TB] CU ignored during load, async reset mid-word");
    doReset();
    applyStimulus(1'b1, 8'd1);
    cuWrite = 1'b1; cuAddr = 8'h07; cuWdata = 16'hBEEF; #1;
    checkOutput("t4 collect write", 32'(ramWriteA), 32'd0);
    checkOutput("t4 collect addr", 32'(ramAddrA), 32'h00);
    sendByte(8'h11, 0);
    cuWrite = 1'b0; cuAddr = 8'h00; cuWdata = 16'h0000;
    #2 reset = 1'b1; #1;
    checkOutput("t5 async rx_ready", 32'(rxReadyA), 32'd0);
    checkOutput("t5 async busy", 32'(busyA), 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    waAddr.delete(); waData.delete(); wbAddr.delete(); wbData.delete();
    applyStimulus(1'b1, 8'd1);
    sendByte(8'h11, 0); sendByte(8'h22, 0);
    waitRun();
    checkOutput("t5 writes", waAddr.size(), 1);
    if (waAddr.size() == 1 && wbAddr.size() == 1) begin
      checkOutput("t5 addr", 32'(waAddr[0]), 32'h01);
      checkOutput("t5 data", 32'(waData[0]), 32'h2211);
      checkOutput("t5 B addr", 32'(wbAddr[0]), 32'hFF);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
